// File: rtl/ts_pkg.sv
// Shared types and constants for the OFDM time-synchronizer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ts_pkg;

    localparam int FFT_POINT  = 64;
    localparam int CP_NUM     = 16;
    localparam int BURST_SIZE = (FFT_POINT + CP_NUM) * 8 + 480;
    localparam int BUF_DEPTH  = 2 * BURST_SIZE;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 8;
    localparam int RD_LAT     = 2;
    localparam int TIMEOUT    = 65535;
    localparam int WD_W       = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        CALC_P = 3'd2,
        CALC_R = 3'd3,
        CALC_M = 3'd4,
        DETECT = 3'd5,
        CP_REM = 3'd6,
        READY  = 3'd7
    } ts_state_t;

endpackage

// File: rtl/ts_buf_port_mux.sv
// Grants the single input-buffer BRAM port to the phase owner; flags foreign requests.
// Latency: 1 cycle to buf_* outputs, RD_LAT more cycles to buf_rd_valid.
// Backpressure: none; non-granted requests are dropped and reported via conflict.
import ts_pkg::*;

module ts_buf_port_mux (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_done,
    input  ts_state_t         state,
    input  logic              wren,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic              p_en,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              cp_en,
    input  logic [ADDR_W-1:0] cp_addr,
    output logic              buf_en,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_di,
    output logic              buf_rd_valid,
    output logic              conflict
);

    logic              en_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] di_d;
    logic [RD_LAT-1:0] rd_pipe;

    always_comb begin
        en_d   = 1'b0;
        we_d   = 1'b0;
        addr_d = '0;
        di_d   = '0;
        case (state)
            IDLE, FILL: begin
                en_d   = wren;
                we_d   = wren;
                addr_d = fill_addr;
                di_d   = din;
            end
            CALC_P: begin
                en_d   = p_en;
                addr_d = p_addr;
            end
            CALC_R: begin
                en_d   = r_en;
                addr_d = r_addr;
            end
            CP_REM: begin
                en_d   = cp_en;
                addr_d = cp_addr;
            end
            default: ;
        endcase
        conflict = (p_en  && (state != CALC_P)) ||
                   (r_en  && (state != CALC_R)) ||
                   (cp_en && (state != CP_REM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_en   <= 1'b0;
            buf_we   <= 1'b0;
            buf_addr <= '0;
            buf_di   <= '0;
            rd_pipe  <= '0;
        end else if (tx_done) begin
            buf_en   <= 1'b0;
            buf_we   <= 1'b0;
            buf_addr <= '0;
            buf_di   <= '0;
            rd_pipe  <= '0;
        end else begin
            buf_en     <= en_d;
            buf_we     <= we_d;
            buf_addr   <= addr_d;
            buf_di     <= di_d;
            // Valid tracks reads issued on the registered port, RD_LAT cycles later.
            rd_pipe[0] <= buf_en & ~buf_we;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign buf_rd_valid = rd_pipe[RD_LAT-1];

endmodule

// File: rtl/timesync_sequencer.sv
// Phase sequencer for the time-synchronizer: fill, P, R, M, detect, CP removal.
// Latency: start pulses and buf_* outputs are registered (1 cycle after the causing edge).
// Backpressure: none; stray samples, stray requests and stalled phases raise sticky errors.
import ts_pkg::*;

module timesync_sequencer (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_done,
    input  logic              wren,
    input  logic [DATA_W-1:0] din,
    output logic              p_start,
    output logic              r_start,
    output logic              m_start,
    output logic              det_start,
    output logic              cp_start,
    input  logic              p_done,
    input  logic              r_done,
    input  logic              m_done,
    input  logic              det_done,
    input  logic              cp_done,
    input  logic              p_en,
    input  logic              r_en,
    input  logic              cp_en,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic [ADDR_W-1:0] cp_addr,
    output logic              buf_en,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_di,
    output logic              buf_rd_valid,
    output logic [2:0]        state,
    output logic              out_buff_full,
    output logic              err_overrun,
    output logic              err_timeout,
    output logic              err_conflict
);

    localparam logic [ADDR_W:0]   FILL_LAST = (ADDR_W+1)'(BUF_DEPTH - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT - 1);

    ts_state_t       cur;
    ts_state_t       nxt;
    logic [ADDR_W:0] fill_cnt;
    logic [WD_W-1:0] watchdog;
    logic [4:0]      start_q;   // {cp, det, m, r, p}
    logic [4:0]      start_d;
    logic            fill_wr;
    logic            phase_done;
    logic            compute;
    logic            timeout;
    logic            overrun;
    logic            conflict;

    always_comb begin
        nxt        = cur;
        fill_wr    = 1'b0;
        phase_done = 1'b0;
        timeout    = 1'b0;
        start_d    = '0;
        compute    = cur inside {CALC_P, CALC_R, CALC_M, DETECT, CP_REM};
        overrun    = wren && !(cur == IDLE || cur == FILL);
        // A done seen while its start pulse is still high is too early and ignored.
        case (cur)
            IDLE, FILL: begin
                if (wren) begin
                    fill_wr = 1'b1;
                    nxt     = (fill_cnt == FILL_LAST) ? CALC_P : FILL;
                end
            end
            CALC_P:  phase_done = p_done   & ~start_q[0];
            CALC_R:  phase_done = r_done   & ~start_q[1];
            CALC_M:  phase_done = m_done   & ~start_q[2];
            DETECT:  phase_done = det_done & ~start_q[3];
            CP_REM:  phase_done = cp_done  & ~start_q[4];
            default: ;
        endcase
        // Compute phases are encoded consecutively, so done advances by one.
        if (phase_done) begin
            nxt = ts_state_t'(cur + 3'd1);
        end else if (compute && (watchdog >= WD_LIMIT)) begin
            nxt     = IDLE;
            timeout = 1'b1;
        end
        if (nxt != cur) begin
            case (nxt)
                CALC_P:  start_d[0] = 1'b1;
                CALC_R:  start_d[1] = 1'b1;
                CALC_M:  start_d[2] = 1'b1;
                DETECT:  start_d[3] = 1'b1;
                CP_REM:  start_d[4] = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur           <= IDLE;
            fill_cnt      <= '0;
            watchdog      <= '0;
            start_q       <= '0;
            out_buff_full <= 1'b0;
            err_overrun   <= 1'b0;
            err_timeout   <= 1'b0;
            err_conflict  <= 1'b0;
        end else if (tx_done) begin
            cur           <= IDLE;
            fill_cnt      <= '0;
            watchdog      <= '0;
            start_q       <= '0;
            out_buff_full <= 1'b0;
            err_overrun   <= 1'b0;
            err_timeout   <= 1'b0;
            err_conflict  <= 1'b0;
        end else begin
            cur           <= nxt;
            start_q       <= start_d;
            out_buff_full <= (nxt == READY);
            if (timeout) begin
                fill_cnt <= '0;
            end else if (fill_wr) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (nxt != cur) begin
                watchdog <= '0;
            end else if (compute && (watchdog != '1)) begin
                watchdog <= watchdog + 1'b1;
            end
            err_overrun  <= err_overrun  | overrun;
            err_timeout  <= err_timeout  | timeout;
            err_conflict <= err_conflict | conflict;
        end
    end

    assign state     = cur;
    assign p_start   = start_q[0];
    assign r_start   = start_q[1];
    assign m_start   = start_q[2];
    assign det_start = start_q[3];
    assign cp_start  = start_q[4];

    ts_buf_port_mux u_port_mux (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_done      (tx_done),
        .state        (cur),
        .wren         (wren),
        .din          (din),
        .fill_addr    (fill_cnt[ADDR_W-1:0]),
        .p_en         (p_en),
        .p_addr       (p_addr),
        .r_en         (r_en),
        .r_addr       (r_addr),
        .cp_en        (cp_en),
        .cp_addr      (cp_addr),
        .buf_en       (buf_en),
        .buf_we       (buf_we),
        .buf_addr     (buf_addr),
        .buf_di       (buf_di),
        .buf_rd_valid (buf_rd_valid),
        .conflict     (conflict)
    );

endmodule

// File: doc/timesync_sequencer.md
Name: timesync_sequencer

Overview:
Central controller for the OFDM time-synchronizer datapath. It sequences the phase engines: input fill, P correlation, R energy, M metric, frame-index detection, then cyclic-prefix removal. It is the single owner of the shared input-buffer BRAM port and grants that port to exactly one requester per phase. It replaces the per-phase ad-hoc drivers of the buffer enable, write-enable and address signals.

Parameters:
BURST_SIZE, 1120, samples in one OFDM burst including CP and preamble ((64+16)*8+480)
BUF_DEPTH, 2240, samples captured before processing starts (2*BURST_SIZE)
ADDR_W, 12, buffer address width
DATA_W, 8, sample width (signed)
RD_LAT, 2, BRAM read latency in cycles, counted from the sequencer's registered outputs
TIMEOUT, 65535, maximum cycles allowed in any compute phase

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_done  in  1  synchronous restart pulse
wren  in  1  input sample valid
din  in  DATA_W  input sample
p_start, r_start, m_start, det_start, cp_start  out  1 each  phase start pulses
p_done, r_done, m_done, det_done, cp_done  in  1 each  phase completion pulses
p_en, r_en, cp_en  in  1 each  engine buffer read requests
p_addr, r_addr, cp_addr  in  ADDR_W each  engine read addresses
buf_en  out  1  buffer BRAM enable
buf_we  out  1  buffer BRAM write enable
buf_addr  out  ADDR_W  buffer BRAM address
buf_di  out  DATA_W  buffer BRAM write data
buf_rd_valid  out  1  BRAM read data valid
state  out  3  current state encoding
out_buff_full  out  1  CP-removed burst ready for readout
err_overrun  out  1  sticky: sample arrived outside IDLE/FILL
err_timeout  out  1  sticky: phase watchdog expired
err_conflict  out  1  sticky: non-granted engine requested the buffer

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all outputs 0; fill_cnt=0; watchdog=0.
- tx_done: synchronous, highest priority after reset. Same effect as reset, but sticky errors also clear. Any wren in the same cycle is dropped.
- States and encodings: IDLE 0, FILL 1, CALC_P 2, CALC_R 3, CALC_M 4, DETECT 5, CP_REM 6, READY 7.
- IDLE -> FILL on first wren. That sample is written at address 0 in the same cycle.
- FILL: each wren writes din at address fill_cnt, then fill_cnt increments. After the write at address BUF_DEPTH-1, the next state is CALC_P.
- Compute-phase chain: CALC_P -> CALC_R on p_done; CALC_R -> CALC_M on r_done; CALC_M -> DETECT on m_done; DETECT -> CP_REM on det_done; CP_REM -> READY on cp_done.
- READY: out_buff_full=1, held until tx_done or reset.
- Start pulses: each x_start is high for exactly one cycle, the cycle after entry into its state. x_done is honoured only in the matching state and only from the cycle after x_start. It is ignored at any other time.
- Buffer port, registered with 1-cycle latency from inputs to buf_* outputs:
  - IDLE/FILL: grant to the writer; buf_we=wren.
  - CALC_P: grant to p_*; buf_we=0.
  - CALC_R: grant to r_*; buf_we=0.
  - CP_REM: grant to cp_*; buf_we=0.
  - All other states: buf_en=0.
  - A request from a non-granted engine is dropped and sets err_conflict.
- buf_rd_valid = (buf_en & ~buf_we) delayed RD_LAT cycles. The pipe is flushed by tx_done and reset.
- err_overrun: set by wren in any state other than IDLE/FILL; the sample is dropped and fill_cnt is unchanged.
- Watchdog:
  - Counter clears on every state entry and counts in CALC_P through CP_REM.
  - Reaching TIMEOUT forces IDLE, sets err_timeout and emits no start pulse.
  - If done and timeout occur in the same cycle, done wins.
- Widths: fill_cnt is ADDR_W+1 bits with no wrap; watchdog is 16 bits and saturates.

Decomposition:
- Shared package ts_pkg:
  - state enum and encodings
  - BURST_SIZE, BUF_DEPTH, FFT_POINT=64, CP_NUM=16
  - ADDR_W, DATA_W
- Sub-module ts_buf_port_mux: registered grant mux plus the RD_LAT valid pipe.
- The FSM, fill counter and watchdog stay in the top module.

Test Plan:
- Nominal: 2240 wren samples (din=addr[7:0]) -> writes 0..2239; state 1->2. Pulse p_done..cp_done 10 cycles after each start -> states 2..7, out_buff_full=1, no errors.
- Grant: in CALC_R drive r_en=1, r_addr=100, plus p_en=1 -> buf_addr=100 one cycle later; buf_rd_valid 2 cycles after that; err_conflict=1.
- Overrun: wren=1 in CALC_P -> err_overrun=1, buf_we stays 0, state 2.
- Timeout: withhold m_done -> after 65535 cycles in CALC_M, state=0, err_timeout=1. Then tx_done -> err_timeout=0.
- Restart: tx_done coincident with wren during CALC_R -> state 0, no write, all flags 0. The next wren writes address 0.
- Spurious done: r_done pulsed in CALC_P, and p_done in the same cycle as p_start -> no transition. A later p_done -> CALC_R.
